// File: rtl/frame_flip_scheduler.sv
// Frame sequencer: starts a render into the back buffer, waits for done, and
// swaps back/front buffers on the next vsync rising edge. All outputs are registered.
module frame_flip_scheduler #(
  parameter int NUM_BUFFERS    = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_VSYNCS = 8,
  parameter int BUF_W          = ($clog2(NUM_BUFFERS) > 0 ? $clog2(NUM_BUFFERS) : 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             vsync,
  input  logic             render_done,
  output logic             render_start,
  output logic [BUF_W-1:0] render_buffer,
  output logic [BUF_W-1:0] display_buffer,
  output logic             flip,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int WD_W = (TIMEOUT_VSYNCS > 0) ? $clog2(TIMEOUT_VSYNCS + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_VSYNCS);
  localparam logic [BUF_W-1:0] LAST_BUF = BUF_W'(NUM_BUFFERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RENDER,
    WAIT_VSYNC,
    FLIP
  } state_t;

  state_t            state, state_d;
  logic              vsync_q;
  logic              vs_edge;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_hit;
  logic              start_d, flip_d, timeout_d, drop_d, wd_clr, wd_inc;

  assign vs_edge = vsync & ~vsync_q;
  assign wd_hit  = (TIMEOUT_VSYNCS != 0) && (wd_cnt == WD_LIMIT);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state;
    start_d   = 1'b0;
    flip_d    = 1'b0;
    timeout_d = 1'b0;
    drop_d    = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_d = START;
      end
      START: begin
        start_d = 1'b1;
        wd_clr  = 1'b1;
        state_d = RENDER;
      end
      RENDER: begin
        // Any edge while still rendering is a missed display opportunity.
        drop_d = vs_edge;
        if (render_done) begin
          state_d = WAIT_VSYNC;
        end else if (wd_hit) begin
          timeout_d = 1'b1;
          state_d   = START;
        end else if (vs_edge) begin
          wd_inc = (TIMEOUT_VSYNCS != 0);
        end
      end
      WAIT_VSYNC: begin
        if (vs_edge) begin
          flip_d  = 1'b1;
          state_d = FLIP;
        end
      end
      FLIP: begin
        state_d = enable ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      vsync_q <= 1'b1;
      wd_cnt  <= '0;
    end else begin
      state   <= state_d;
      vsync_q <= vsync;
      if (wd_clr)      wd_cnt <= '0;
      else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Pulses are registered from the decisions above, so each lands one cycle after it is taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      render_start   <= 1'b0;
      flip           <= 1'b0;
      timeout        <= 1'b0;
      busy           <= 1'b0;
      display_buffer <= '0;
      render_buffer  <= BUF_W'(1);
      frame_count    <= '0;
      drop_count     <= '0;
    end else begin
      render_start <= start_d;
      flip         <= flip_d;
      timeout      <= timeout_d;
      busy         <= (state_d != IDLE);
      if (flip_d) begin
        display_buffer <= render_buffer;
        render_buffer  <= (render_buffer == LAST_BUF) ? '0 : render_buffer + 1'b1;
        frame_count    <= frame_count + 1'b1;
      end
      if (drop_d && (drop_count != CNT_MAX)) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_flip_scheduler.sv
// Self-checking bench for frame_flip_scheduler: a 2-buffer and a 3-buffer instance
// share stimulus; flip contents are scoreboarded, timing is checked inline.
module tb_frame_flip_scheduler;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic vsync = 1'b1;
  logic render_done = 1'b0;

  logic        rs, flip, busy, timeout;
  logic [0:0]  rb, db;
  logic [15:0] fc, dc;
  logic        rs3, flip3, busy3, timeout3;
  logic [1:0]  rb3, db3;
  logic [15:0] fc3, dc3;

  always #5 clk = ~clk;

  frame_flip_scheduler #(.NUM_BUFFERS(2), .CNT_W(16), .TIMEOUT_VSYNCS(8)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .vsync(vsync), .render_done(render_done),
    .render_start(rs), .render_buffer(rb), .display_buffer(db), .flip(flip), .busy(busy),
    .timeout(timeout), .frame_count(fc), .drop_count(dc)
  );

  frame_flip_scheduler #(.NUM_BUFFERS(3), .CNT_W(16), .TIMEOUT_VSYNCS(8)) dut3 (
    .clk(clk), .resetn(resetn), .enable(enable), .vsync(vsync), .render_done(render_done),
    .render_start(rs3), .render_buffer(rb3), .display_buffer(db3), .flip(flip3), .busy(busy3),
    .timeout(timeout3), .frame_count(fc3), .drop_count(dc3)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int disp;
    int rend;
    int fcnt;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;
  int   m_rend2, m_rend3, m_fc;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flip();
    m_fc++;
    e2 = '{disp: m_rend2, rend: (m_rend2 + 1) % 2, fcnt: m_fc};
    e3 = '{disp: m_rend3, rend: (m_rend3 + 1) % 3, fcnt: m_fc};
    q2.push_back(e2);
    q3.push_back(e3);
    m_rend2 = e2.rend;
    m_rend3 = e3.rend;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_db"}, db, 0);
    check({tag, "_rb"}, rb, 1);
    check({tag, "_rs"}, rs, 0);
    check({tag, "_flip"}, flip, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_fc"}, fc, 0);
    check({tag, "_dc"}, dc, 0);
    check({tag, "_rb3"}, rb3, 1);
    check({tag, "_db3"}, db3, 0);
  endtask

  // Starts in the first RENDER cycle (render_start just observed) with vsync low.
  task automatic run_frame(input int done_gap, input int vs_gap, input int expect_restart);
    repeat (done_gap) tick();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    repeat (vs_gap) tick();
    check("no_early_flip", flip, 0);
    push_flip();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("flip_latency", flip, 1);
    tick();
    check("flip_one_cycle", flip, 0);
    check("start_not_yet", rs, 0);
    tick();
    check("restart_after_flip", rs, expect_restart);
    if (expect_restart != 0) check("rb_at_start", rb, m_rend2);
  endtask

  // Scoreboard: compare buffer indices and frame count whenever a flip appears.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (flip) begin
        if (q2.size() == 0) check("flip2_unexpected", 1, 0);
        else begin
          e2 = q2.pop_front();
          check("sb_disp2", db, e2.disp);
          check("sb_rend2", rb, e2.rend);
          check("sb_fcnt2", fc, e2.fcnt);
        end
      end
      if (flip3) begin
        if (q3.size() == 0) check("flip3_unexpected", 1, 0);
        else begin
          e3 = q3.pop_front();
          check("sb_disp3", db3, e3.disp);
          check("sb_rend3", rb3, e3.rend);
          check("sb_fcnt3", fc3, e3.fcnt);
          check("rb3_ne_db3", int'(rb3 != db3), 1);
        end
      end
    end
  end

  initial begin
    int seen;

    // T1: reset values, then release with enable=1 and vsync held high.
    resetn = 1'b0;
    enable = 1'b1;
    vsync  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    m_rend2 = 1;
    m_rend3 = 1;
    m_fc    = 0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("t1_rs_edge1", rs, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_rs_edge2", rs, 1);
    check("t1_rb", rb, 1);
    check("t1_db", db, 0);
    vsync = 1'b0;
    tick();
    check("t1_rs_once", rs, 0);
    check("t1_no_drop", dc, 0);
    check("t1_no_flip", flip, 0);

    // T2 then T3: three complete frames; 3-buffer display runs 1,2,0.
    run_frame(15, 20, 1);
    run_frame(3, 5, 1);
    run_frame(1, 1, 1);
    check("t3_db3_final", db3, 0);
    check("t3_fc", fc, 3);

    // T4: no render_done, eight vsync edges -> watchdog abort.
    for (int i = 0; i < 8; i++) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      check("t4_no_early_timeout", timeout, 0);
      if (i != 7) tick();
    end
    check("t4_drops", dc, 8);
    tick();
    check("t4_timeout", timeout, 1);
    check("t4_no_start_yet", rs, 0);
    check("t4_fc_unchanged", fc, m_fc);
    tick();
    check("t4_timeout_pulse", timeout, 0);
    check("t4_restart", rs, 1);
    check("t4_same_rb", rb, m_rend2);
    check("t4_same_rb3", rb3, m_rend3);

    // T5: render_done together with a vsync edge.
    tick();
    render_done = 1'b1;
    vsync = 1'b1;
    tick();
    render_done = 1'b0;
    vsync = 1'b0;
    check("t5_drop", dc, 9);
    check("t5_no_flip", flip, 0);
    tick();
    tick();
    check("t5_still_no_flip", flip, 0);
    push_flip();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("t5_flip_next_edge", flip, 1);
    check("t5_drop_stable", dc, 9);
    tick();
    tick();
    check("t5_restart", rs, 1);

    // T6: enable dropped during RENDER; frame completes, then idle.
    tick();
    enable = 1'b0;
    run_frame(2, 3, 0);
    check("t6_idle_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rs || busy) seen = 1;
    end
    check("t6_stays_idle", seen, 0);
    check("sb_drained", q2.size() + q3.size(), 0);

    // T6: async reset in the middle of a render.
    enable = 1'b1;
    tick();
    tick();
    check("t6_rs_again", rs, 1);
    repeat (4) tick();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("midrst");
    q2.delete();
    q3.delete();
    m_rend2 = 1;
    m_rend3 = 1;
    m_fc    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("post_rst_rs", rs, 0);
    tick();
    check("post_rst_start", rs, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
